// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and constants for the memory->writeback stage and its register file.
package mem_wb_stage_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int RET_W  = 64;
  localparam int NREGS  = 1 << REG_AW;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/mem_wb_stage_regfile_2r1w.sv
// Integer register file: one synchronous write port, two combinational read ports
// that see a same-cycle write through the bypass path; x0 is hardwired to zero.
module regfile_2r1w
  import mem_wb_stage_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int AW = REG_AW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] regs_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Bypass lets decode see the value committing this cycle without waiting a clock.
  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
    logic [DW-1:0] val;
    if (addr == '0)                  val = '0;
    else if (we_i && addr == waddr_i) val = wdata_i;
    else                             val = regs_q[addr];
    return val;
  endfunction

  always_comb begin
    rdata1_o = read_port(raddr1_i);
    rdata2_o = read_port(raddr2_i);
  end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory->writeback pipeline register, commit logic, retire counter and the
// register file that the writeback stage commits into.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              execute_vaild_i,
  input  logic              ED_load_i,
  input  logic              ED_reg_wen_i,
  input  logic [REG_AW-1:0] ED_rd_i,
  input  logic [XLEN-1:0]   ED_valE_i,
  input  logic [XLEN-1:0]   M_valM_i,
  input  logic [XLEN-1:0]   ED_pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] D_rs1_addr_i,
  input  logic [REG_AW-1:0] D_rs2_addr_i,
  output logic [XLEN-1:0]   D_rs1_data_o,
  output logic [XLEN-1:0]   D_rs2_data_o,
  output logic              W_valid_o,
  output logic [REG_AW-1:0] W_rd_o,
  output logic              W_wen_o,
  output logic [XLEN-1:0]   W_data_o,
  output logic [XLEN-1:0]   W_pc_o,
  output logic              W_commit_o,
  output logic [RET_W-1:0]  W_retire_cnt_o
);
  logic              valid_q, valid_d;
  logic              wen_q, wen_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [RET_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic              commit;

  // A stalled W instruction simply waits; it retires on the first unstalled cycle.
  assign commit = valid_q & ~stall_i;

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    rd_d    = rd_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
      wen_d   = 1'b0;
    end else if (!stall_i) begin
      valid_d = execute_vaild_i;
      wen_d   = ED_reg_wen_i & execute_vaild_i & (ED_rd_i != ZERO_REG);
      rd_d    = ED_rd_i;
      data_d  = ED_load_i ? M_valM_i : ED_valE_i;
      pc_d    = ED_pc_i;
    end
    retire_cnt_d = retire_cnt_q + RET_W'(commit);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q      <= 1'b0;
      wen_q        <= 1'b0;
      rd_q         <= '0;
      data_q       <= '0;
      pc_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      wen_q        <= wen_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
      pc_q         <= pc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  regfile_2r1w #(.DW(XLEN), .AW(REG_AW)) u_regfile (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (commit & wen_q),
    .waddr_i  (rd_q),
    .wdata_i  (data_q),
    .raddr1_i (D_rs1_addr_i),
    .raddr2_i (D_rs2_addr_i),
    .rdata1_o (D_rs1_data_o),
    .rdata2_o (D_rs2_data_o)
  );

  assign W_valid_o      = valid_q;
  assign W_rd_o         = rd_q;
  assign W_wen_o        = wen_q;
  assign W_data_o       = data_q;
  assign W_pc_o         = pc_q;
  assign W_commit_o     = commit;
  assign W_retire_cnt_o = retire_cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a per-cycle vector table plus reset and counter-wrap sequences.
module tb_mem_wb_stage;
  logic        clk_i, rst_n_i;
  logic        execute_vaild_i, ED_load_i, ED_reg_wen_i;
  logic [4:0]  ED_rd_i;
  logic [31:0] ED_valE_i, M_valM_i, ED_pc_i;
  logic        stall_i, flush_i;
  logic [4:0]  D_rs1_addr_i, D_rs2_addr_i;
  logic [31:0] D_rs1_data_o, D_rs2_data_o;
  logic        W_valid_o, W_wen_o, W_commit_o;
  logic [4:0]  W_rd_o;
  logic [31:0] W_data_o, W_pc_o;
  logic [63:0] W_retire_cnt_o;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .execute_vaild_i(execute_vaild_i), .ED_load_i(ED_load_i), .ED_reg_wen_i(ED_reg_wen_i),
    .ED_rd_i(ED_rd_i), .ED_valE_i(ED_valE_i), .M_valM_i(M_valM_i), .ED_pc_i(ED_pc_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .D_rs1_addr_i(D_rs1_addr_i), .D_rs2_addr_i(D_rs2_addr_i),
    .D_rs1_data_o(D_rs1_data_o), .D_rs2_data_o(D_rs2_data_o),
    .W_valid_o(W_valid_o), .W_rd_o(W_rd_o), .W_wen_o(W_wen_o), .W_data_o(W_data_o),
    .W_pc_o(W_pc_o), .W_commit_o(W_commit_o), .W_retire_cnt_o(W_retire_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        vld, ld, wen;
    logic [4:0]  rd;
    logic [31:0] vale, valm, pc;
    logic        stall, flush;
    logic [4:0]  rs1, rs2;
    logic        e_valid, e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_pc;
    logic        e_commit;
    logic [63:0] e_cnt;
    logic [31:0] e_rs1, e_rs2;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    execute_vaild_i = v.vld;  ED_load_i = v.ld;  ED_reg_wen_i = v.wen;
    ED_rd_i = v.rd;  ED_valE_i = v.vale;  M_valM_i = v.valm;  ED_pc_i = v.pc;
    stall_i = v.stall;  flush_i = v.flush;
    D_rs1_addr_i = v.rs1;  D_rs2_addr_i = v.rs2;
  endtask

  task automatic idle_inputs();
    execute_vaild_i = 0; ED_load_i = 0; ED_reg_wen_i = 0; ED_rd_i = 0;
    ED_valE_i = 0; M_valM_i = 0; ED_pc_i = 0; stall_i = 0; flush_i = 0;
    D_rs1_addr_i = 0; D_rs2_addr_i = 0;
  endtask

  initial begin
    //          vld ld wen rd  valE          valM          pc     stl fl rs1 rs2  eV eW eRd eData         ePC    eCm eCnt eRs1          eRs2
    vecs[0]  = '{1, 0, 1, 5,  32'h1234,     32'h0,        32'h100, 0, 0, 5,  0,  1, 1, 5,  32'h1234,     32'h100, 1, 0, 32'h1234,     32'h0};
    vecs[1]  = '{1, 1, 1, 7,  32'h100,      32'hFFFFFF80, 32'h104, 0, 0, 5,  7,  1, 1, 7,  32'hFFFFFF80, 32'h104, 1, 1, 32'h1234,     32'hFFFFFF80};
    vecs[2]  = '{1, 0, 1, 0,  32'hDEAD,     32'h0,        32'h108, 0, 0, 0,  7,  1, 0, 0,  32'hDEAD,     32'h108, 1, 2, 32'h0,        32'hFFFFFF80};
    vecs[3]  = '{1, 0, 1, 5,  32'hAAAA0001, 32'h0,        32'h10C, 0, 0, 5,  0,  1, 1, 5,  32'hAAAA0001, 32'h10C, 1, 3, 32'hAAAA0001, 32'h0};
    vecs[4]  = '{1, 0, 1, 9,  32'h9999,     32'h0,        32'h110, 1, 0, 5,  9,  1, 1, 5,  32'hAAAA0001, 32'h10C, 0, 3, 32'h1234,     32'h0};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{1, 0, 1, 9,  32'h9999,     32'h0,        32'h110, 0, 0, 5,  9,  1, 1, 9,  32'h9999,     32'h110, 1, 4, 32'hAAAA0001, 32'h9999};
    vecs[8]  = '{1, 0, 1, 10, 32'h5555,     32'h0,        32'h114, 1, 1, 9,  5,  0, 0, 9,  32'h9999,     32'h110, 0, 4, 32'h0,        32'hAAAA0001};
    vecs[9]  = '{1, 0, 1, 11, 32'h0B0B,     32'h0,        32'h118, 0, 0, 11, 9,  1, 1, 11, 32'h0B0B,     32'h118, 1, 4, 32'h0B0B,     32'h0};
    vecs[10] = '{1, 0, 1, 12, 32'hCCCC,     32'h0,        32'h11C, 0, 1, 11, 12, 0, 0, 11, 32'h0B0B,     32'h118, 0, 5, 32'h0B0B,     32'h0};
    vecs[11] = '{0, 0, 1, 13, 32'h1313,     32'h0,        32'h120, 0, 0, 13, 11, 0, 0, 13, 32'h1313,     32'h120, 0, 5, 32'h0,        32'h0B0B};
    vecs[12] = '{1, 0, 1, 20, 32'h1,        32'h0,        32'h124, 0, 0, 20, 20, 1, 1, 20, 32'h1,        32'h124, 1, 5, 32'h1,        32'h1};
    vecs[13] = '{1, 0, 1, 20, 32'h2,        32'h0,        32'h128, 0, 0, 20, 20, 1, 1, 20, 32'h2,        32'h128, 1, 6, 32'h2,        32'h2};
    vecs[14] = '{0, 0, 0, 0,  32'h0,        32'h0,        32'h12C, 0, 0, 20, 20, 0, 0, 0,  32'h0,        32'h12C, 0, 7, 32'h2,        32'h2};

    // Power-on reset
    rst_n_i = 1'b0;
    idle_inputs();
    D_rs1_addr_i = 5'd5;
    #12;
    check("reset_valid", 64'(W_valid_o), 64'd0);
    check("reset_wen", 64'(W_wen_o), 64'd0);
    check("reset_rd", 64'(W_rd_o), 64'd0);
    check("reset_data", 64'(W_data_o), 64'd0);
    check("reset_pc", 64'(W_pc_o), 64'd0);
    check("reset_cnt", W_retire_cnt_o, 64'd0);
    check("reset_rs1", 64'(D_rs1_data_o), 64'd0);
    $display("reset: valid=%0d cnt=%0d rs1=%0h", W_valid_o, W_retire_cnt_o, D_rs1_data_o);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vecs[i]);
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_valid", i), 64'(W_valid_o), 64'(vecs[i].e_valid));
      check($sformatf("v%0d_wen", i), 64'(W_wen_o), 64'(vecs[i].e_wen));
      check($sformatf("v%0d_rd", i), 64'(W_rd_o), 64'(vecs[i].e_rd));
      check($sformatf("v%0d_data", i), 64'(W_data_o), 64'(vecs[i].e_data));
      check($sformatf("v%0d_pc", i), 64'(W_pc_o), 64'(vecs[i].e_pc));
      check($sformatf("v%0d_commit", i), 64'(W_commit_o), 64'(vecs[i].e_commit));
      check($sformatf("v%0d_cnt", i), W_retire_cnt_o, vecs[i].e_cnt);
      check($sformatf("v%0d_rs1", i), 64'(D_rs1_data_o), 64'(vecs[i].e_rs1));
      check($sformatf("v%0d_rs2", i), 64'(D_rs2_data_o), 64'(vecs[i].e_rs2));
      $display("vec %0d: W valid=%0d wen=%0d rd=%0d data=%h commit=%0d cnt=%0d rs1=%h rs2=%h",
               i, W_valid_o, W_wen_o, W_rd_o, W_data_o, W_commit_o, W_retire_cnt_o,
               D_rs1_data_o, D_rs2_data_o);
    end

    // Reset asserted mid-cycle while W holds a valid instruction
    @(negedge clk_i);
    idle_inputs();
    execute_vaild_i = 1; ED_reg_wen_i = 1; ED_rd_i = 5'd3; ED_valE_i = 32'h33; ED_pc_i = 32'h200;
    D_rs1_addr_i = 5'd5; D_rs2_addr_i = 5'd20;
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("midrst_valid", 64'(W_valid_o), 64'd0);
    check("midrst_wen", 64'(W_wen_o), 64'd0);
    check("midrst_rd", 64'(W_rd_o), 64'd0);
    check("midrst_data", 64'(W_data_o), 64'd0);
    check("midrst_pc", 64'(W_pc_o), 64'd0);
    check("midrst_commit", 64'(W_commit_o), 64'd0);
    check("midrst_cnt", W_retire_cnt_o, 64'd0);
    check("midrst_rs1", 64'(D_rs1_data_o), 64'd0);
    check("midrst_rs2", 64'(D_rs2_data_o), 64'd0);
    $display("mid-reset: valid=%0d cnt=%0d rs1=%h rs2=%h", W_valid_o, W_retire_cnt_o, D_rs1_data_o, D_rs2_data_o);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle_inputs();
    @(posedge clk_i);
    #1;
    check("postrst_commit", 64'(W_commit_o), 64'd0);
    check("postrst_cnt", W_retire_cnt_o, 64'd0);
    $display("post-reset bubble: commit=%0d cnt=%0d", W_commit_o, W_retire_cnt_o);

    // Retire counter wrap
    @(negedge clk_i);
    force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    check("wrap_preset", W_retire_cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
    execute_vaild_i = 1; ED_rd_i = 5'd0; ED_pc_i = 32'h300;
    @(posedge clk_i);
    #1;
    check("wrap_commit", 64'(W_commit_o), 64'd1);
    check("wrap_hold", W_retire_cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk_i);
    idle_inputs();
    @(posedge clk_i);
    #1;
    check("wrap_zero", W_retire_cnt_o, 64'd0);
    $display("wrap: cnt=%0d", W_retire_cnt_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
